// File: rtl/if_stage.sv
// Instruction fetch stage: one outstanding SRAM read, a single-entry output
// register handed to decode by a valid/ready handshake, and branch redirect.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h1c00_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        inst_sram_en,
    output logic        inst_sram_we,
    output logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_wdata,
    input  logic [31:0] inst_sram_rdata,
    input  logic        ds_ready,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic        fs_valid,
    output logic [31:0] fs_inst,
    output logic [31:0] fs_pc,
    output logic        fs_adef
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP,
        VALID
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] fs_inst_q, fs_inst_d;
    logic [31:0] fs_pc_q, fs_pc_d;
    logic        fs_adef_q, fs_adef_d;
    logic        misaligned;

    assign misaligned = |pc_q[1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC;
            fs_inst_q <= 32'h0;
            fs_pc_q   <= 32'h0;
            fs_adef_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            fs_inst_q <= fs_inst_d;
            fs_pc_q   <= fs_pc_d;
            fs_adef_q <= fs_adef_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        fs_inst_d    = fs_inst_q;
        fs_pc_d      = fs_pc_q;
        fs_adef_d    = fs_adef_q;
        inst_sram_en = 1'b0;
        case (state_q)
            IDLE: begin
                state_d = REQ;
                if (br_taken) begin
                    pc_d = br_target;
                end
            end
            REQ: begin
                // The request for the old pc still goes out on a redirect;
                // its response lands in REQ next cycle and is simply ignored.
                inst_sram_en = !misaligned;
                if (br_taken) begin
                    pc_d    = br_target;
                    state_d = REQ;
                end else if (misaligned) begin
                    fs_inst_d = 32'h0;
                    fs_pc_d   = pc_q;
                    fs_adef_d = 1'b1;
                    state_d   = VALID;
                end else begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (br_taken) begin
                    pc_d    = br_target;
                    state_d = REQ;
                end else begin
                    fs_inst_d = inst_sram_rdata;
                    fs_pc_d   = pc_q;
                    fs_adef_d = 1'b0;
                    state_d   = VALID;
                end
            end
            VALID: begin
                if (ds_ready || br_taken) begin
                    pc_d    = br_taken ? br_target : pc_q + 32'd4;
                    state_d = REQ;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign inst_sram_we    = 1'b0;
    assign inst_sram_wdata = 32'h0;
    assign inst_sram_addr  = pc_q;
    assign fs_valid        = (state_q == VALID);
    assign fs_inst         = fs_inst_q;
    assign fs_pc           = fs_pc_q;
    assign fs_adef         = fs_adef_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: a one-cycle-latency SRAM model feeds the stage
// and every expected value below is worked out by hand from the fetch timeline.
module tb_if_stage;

    localparam logic [31:0] RESET_PC = 32'h1c00_0000;

    logic        clk;
    logic        reset;
    logic        inst_sram_en;
    logic        inst_sram_we;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata;
    logic        ds_ready;
    logic        br_taken;
    logic [31:0] br_target;
    logic        fs_valid;
    logic [31:0] fs_inst;
    logic [31:0] fs_pc;
    logic        fs_adef;

    int checks = 0;
    int passes = 0;

    if_stage #(.RESET_PC(RESET_PC)) dut (
        .clk             (clk),
        .reset           (reset),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_we    (inst_sram_we),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_wdata (inst_sram_wdata),
        .inst_sram_rdata (inst_sram_rdata),
        .ds_ready        (ds_ready),
        .br_taken        (br_taken),
        .br_target       (br_target),
        .fs_valid        (fs_valid),
        .fs_inst         (fs_inst),
        .fs_pc           (fs_pc),
        .fs_adef         (fs_adef)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        if (a == 32'h1c00_0000) return 32'h0280_0421;
        return ~a ^ 32'h1234_5678;
    endfunction

    // Synchronous SRAM: data for an enabled address appears the next cycle.
    always @(posedge clk) begin
        if (inst_sram_en) inst_sram_rdata <= memWord(inst_sram_addr);
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) passes++;
        else $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    endtask

    task automatic applyStimulus(input logic ready, input logic br, input logic [31:0] target);
        ds_ready  = ready;
        br_taken  = br;
        br_target = target;
    endtask

    task automatic nextCycle();
        @(negedge clk);
    endtask

    task automatic checkFetch(input string tag, input logic en, input logic [31:0] addr, input logic valid);
        checkOutput({tag, ".en"}, {31'b0, inst_sram_en}, {31'b0, en});
        if (en) checkOutput({tag, ".addr"}, inst_sram_addr, addr);
        checkOutput({tag, ".valid"}, {31'b0, fs_valid}, {31'b0, valid});
    endtask

    task automatic checkHeld(input string tag, input logic [31:0] inst, input logic [31:0] pc, input logic adef);
        checkOutput({tag, ".valid"}, {31'b0, fs_valid}, 32'd1);
        checkOutput({tag, ".inst"}, fs_inst, inst);
        checkOutput({tag, ".pc"}, fs_pc, pc);
        checkOutput({tag, ".adef"}, {31'b0, fs_adef}, {31'b0, adef});
        checkOutput({tag, ".en"}, {31'b0, inst_sram_en}, 32'd0);
    endtask

    initial begin
        inst_sram_rdata = 32'h0;
        reset = 1'b1;
        applyStimulus(1'b1, 1'b0, 32'h0);
        repeat (3) nextCycle();

        checkOutput("rst.en", {31'b0, inst_sram_en}, 32'd0);
        checkOutput("rst.valid", {31'b0, fs_valid}, 32'd0);
        checkOutput("rst.addr", inst_sram_addr, RESET_PC);
        checkOutput("rst.inst", fs_inst, 32'h0);
        checkOutput("rst.pc", fs_pc, 32'h0);
        checkOutput("rst.adef", {31'b0, fs_adef}, 32'd0);
        checkOutput("rst.we", {31'b0, inst_sram_we}, 32'd0);
        checkOutput("rst.wdata", inst_sram_wdata, 32'h0);

        // Cycle 0 after release is IDLE; request goes out in cycle 1.
        reset = 1'b0;
        checkFetch("c0_idle", 1'b0, 32'h0, 1'b0);
        nextCycle();
        checkFetch("c1_req", 1'b1, 32'h1c00_0000, 1'b0);
        nextCycle();
        checkFetch("c2_resp", 1'b0, 32'h0, 1'b0);
        nextCycle();
        checkHeld("c3_valid", 32'h0280_0421, 32'h1c00_0000, 1'b0);
        nextCycle();
        checkFetch("c4_req", 1'b1, 32'h1c00_0004, 1'b0);

        // Stall decode for five cycles while the second instruction is held.
        applyStimulus(1'b0, 1'b0, 32'h0);
        nextCycle();
        checkFetch("c5_resp", 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            nextCycle();
            checkHeld("stall", memWord(32'h1c00_0004), 32'h1c00_0004, 1'b0);
        end
        applyStimulus(1'b1, 1'b0, 32'h0);
        nextCycle();
        checkFetch("after_stall_req", 1'b1, 32'h1c00_0008, 1'b0);

        // Redirect while the fetch of 0x1c000008 is in RESP.
        nextCycle();
        checkFetch("resp_008", 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b1, 1'b1, 32'h1c00_0200);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 32'h0);
        checkFetch("squash_req", 1'b1, 32'h1c00_0200, 1'b0);
        nextCycle();
        checkFetch("squash_resp", 1'b0, 32'h0, 1'b0);
        nextCycle();
        checkHeld("squash_valid", memWord(32'h1c00_0200), 32'h1c00_0200, 1'b0);

        // Taken branch on the handshake itself.
        applyStimulus(1'b1, 1'b1, 32'h1c00_0100);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 32'h0);
        checkFetch("br_req", 1'b1, 32'h1c00_0100, 1'b0);
        nextCycle();
        checkFetch("br_resp", 1'b0, 32'h0, 1'b0);
        nextCycle();
        checkHeld("br_valid", memWord(32'h1c00_0100), 32'h1c00_0100, 1'b0);

        // Misaligned target raises adef without touching the SRAM.
        applyStimulus(1'b1, 1'b1, 32'h1c00_0102);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkFetch("adef_req", 1'b0, 32'h0, 1'b0);
        nextCycle();
        checkHeld("adef_valid", 32'h0, 32'h1c00_0102, 1'b1);

        // Wraparound of pc+4 at the top of the address space.
        applyStimulus(1'b1, 1'b1, 32'hffff_fffc);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 32'h0);
        checkFetch("top_req", 1'b1, 32'hffff_fffc, 1'b0);
        nextCycle();
        nextCycle();
        checkHeld("top_valid", memWord(32'hffff_fffc), 32'hffff_fffc, 1'b0);
        nextCycle();
        checkFetch("wrap_req", 1'b1, 32'h0000_0000, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0);
        nextCycle();
        nextCycle();
        checkHeld("wrap_valid", memWord(32'h0), 32'h0, 1'b0);

        // Asynchronous reset in the middle of VALID.
        reset = 1'b1;
        #1;
        checkOutput("midrst.valid", {31'b0, fs_valid}, 32'd0);
        checkOutput("midrst.en", {31'b0, inst_sram_en}, 32'd0);
        checkOutput("midrst.pc", fs_pc, 32'h0);
        checkOutput("midrst.inst", fs_inst, 32'h0);
        checkOutput("midrst.addr", inst_sram_addr, RESET_PC);
        applyStimulus(1'b1, 1'b0, 32'h0);
        nextCycle();
        reset = 1'b0;
        checkFetch("rel_idle", 1'b0, 32'h0, 1'b0);
        nextCycle();
        checkFetch("rel_req", 1'b1, RESET_PC, 1'b0);
        nextCycle();
        nextCycle();
        checkHeld("rel_valid", 32'h0280_0421, RESET_PC, 1'b0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h1c00_0000, meaning the first fetch address after reset.
REQ-002 The block SHALL have port clk  input  1  sole clock, all state updates on its rising edge.
REQ-003 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 The block SHALL have port inst_sram_en  output  1  fetch request strobe.
REQ-005 The block SHALL have port inst_sram_we  output  1  write enable, constant 0.
REQ-006 The block SHALL have port inst_sram_addr  output  32  fetch byte address.
REQ-007 The block SHALL have port inst_sram_wdata  output  32  write data, constant 0.
REQ-008 The block SHALL have port inst_sram_rdata  input  32  read data, valid the cycle after inst_sram_en=1.
REQ-009 The block SHALL have port ds_ready  input  1  decode stage accepts the held instruction.
REQ-010 The block SHALL have port br_taken  input  1  redirect request.
REQ-011 The block SHALL have port br_target  input  32  redirect address.
REQ-012 The block SHALL have port fs_valid  output  1  fs_inst/fs_pc/fs_adef hold a valid instruction.
REQ-013 The block SHALL have port fs_inst  output  32  fetched instruction word.
REQ-014 The block SHALL have port fs_pc  output  32  address of fs_inst.
REQ-015 The block SHALL have port fs_adef  output  1  fetch address misaligned (pc[1:0]!=0).

Function
REQ-016 The block SHALL implement four states: IDLE, REQ, RESP, VALID.
REQ-017 IDLE: en=0; next state REQ unconditionally.
REQ-018 REQ with pc[1:0]==0: en=1, addr=pc; next RESP.
REQ-019 REQ with pc[1:0]!=0: en=0; fs_inst<=0, fs_pc<=pc, fs_adef<=1; next VALID.
REQ-020 RESP: fs_inst<=inst_sram_rdata, fs_pc<=pc, fs_adef<=0; next VALID.
REQ-021 VALID: fs_valid=1; fs_valid SHALL be 0 in every other state.
REQ-022 Handshake fires when fs_valid=1 and ds_ready=1; on fire pc<=br_taken ? br_target : pc+4, next REQ.
REQ-023 VALID without fire: outputs SHALL hold stable, state unchanged, no SRAM request.
REQ-024 VALID, br_taken=1, ds_ready=0: held instruction discarded, pc<=br_target, next REQ.
REQ-025 br_taken=1 in REQ or RESP: in-flight fetch squashed (RESP data not latched), pc<=br_target, next REQ; REQ still drives en for the old pc that cycle.
REQ-026 br_taken in IDLE: pc<=br_target, next REQ.
REQ-027 pc+4 SHALL wrap modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000).
REQ-028 inst_sram_addr SHALL equal pc in all states; inst_sram_en alone qualifies it.
REQ-029 Latency: request cycle t, fs_valid=1 from cycle t+2; back-to-back throughput one instruction per 3 cycles with ds_ready=1.
REQ-030 At most one SRAM request SHALL be outstanding.

Reset
REQ-031 While reset=1: state=IDLE, pc=RESET_PC, fs_valid=0, fs_inst=0, fs_pc=0, fs_adef=0, inst_sram_en=0, immediately (asynchronous).
REQ-032 Reset asserted in RESP or VALID SHALL discard the pending/held instruction; first request after release addresses RESET_PC in the second cycle after release.

Verification
REQ-033 Release reset, ds_ready=1, mem[0x1c000000]=0x02800421 -> en=1 addr=0x1c000000 cycle 1, fs_valid=1 fs_inst=0x02800421 fs_pc=0x1c000000 cycle 3, next request addr=0x1c000004 cycle 4.
REQ-034 ds_ready=0 for 5 cycles in VALID -> fs_valid, fs_inst, fs_pc stable, inst_sram_en=0 throughout; ds_ready=1 -> next request addr=pc+4.
REQ-035 Fire with br_taken=1 br_target=0x1c000100 -> next request addr=0x1c000100, fs_pc=0x1c000100 two cycles later.
REQ-036 br_taken=1 br_target=0x1c000200 during RESP of 0x1c000008 -> no fs_valid for 0x1c000008; next fs_pc=0x1c000200.
REQ-037 br_target=0x1c000102 -> en stays 0, fs_valid=1 fs_adef=1 fs_inst=0 fs_pc=0x1c000102.
REQ-038 pc=0xFFFFFFFC fired with br_taken=0 -> next request addr=0x00000000; reset pulse mid-VALID -> fs_valid=0 immediately, next fetch at RESET_PC.
